// File: rtl/lx32_branch_pkg.sv
// Shared types for the LX32 branch resolution path: FSM states, predictor
// counter type and the saturating-counter update rule.
package lx32_branch_pkg;

  typedef enum logic {
    BP_IDLE     = 1'b0,
    BP_REDIRECT = 1'b1
  } bp_state_e;

  localparam int BHT_CTR_W = 2;

  typedef logic [BHT_CTR_W-1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET_VAL = 2'b01;

  // Saturating 2-bit counter step: toward 3 when taken, toward 0 otherwise.
  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'd1;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Bimodal predictor table: combinational lookup, one saturating update per
// cycle, every entry restored to weakly not-taken on reset.
module branch_history_table
  import lx32_branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t ctr_q [DEPTH];
  bht_ctr_t rd_ctr;

  // A same-cycle write to rd_idx lands on the edge, so lookups see the old value.
  assign rd_ctr   = ctr_q[rd_idx];
  assign rd_taken = rd_ctr[1];

  // NOTE: this array is reset on purpose; decode must see a defined prediction
  // after reset, so it is built from flops rather than an unresettable RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_RESET_VAL;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= bht_next(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: mispredict detection, redirect handshake to
// fetch with front-end flush, predictor training and branch statistics.
module branch_resolve_ctrl
  import lx32_branch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] id_pc,
  output logic             id_pred_taken,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_front,
  output logic             stall_ex,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  bp_state_e        state_q;
  logic             redirect_valid_q;
  logic [WIDTH-1:0] redirect_pc_q;
  logic             flush_q;
  logic             stall_q;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  logic             resolve;
  logic             actual;
  logic             mispredict;
  logic [WIDTH-1:0] correct_pc;

  // Wrong-path EX contents during REDIRECT are ignored by gating on IDLE.
  assign resolve    = ex_valid & (ex_is_branch | ex_is_jump) & (state_q == BP_IDLE);
  assign actual     = ex_is_jump | branch_taken;
  assign mispredict = resolve & (actual != ex_pred_taken);
  assign correct_pc = actual ? ex_target : ex_pc + WIDTH'(4);

  // Only the index bits of the decode PC address the table.
  logic unused_id_pc;
  assign unused_id_pc = ^{id_pc[WIDTH-1:IDX_W+2], id_pc[1:0]};

  branch_history_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (id_pc[IDX_W+1:2]),
    .rd_taken (id_pred_taken),
    .wr_en    (resolve & ex_is_branch),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (branch_taken)
  );

  // NOTE: next-state logic assigns defaults before any condition so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= BP_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
    end else begin
      case (state_q)
        BP_IDLE: begin
          if (mispredict) begin
            state_q          <= BP_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= correct_pc;
            flush_q          <= 1'b1;
            stall_q          <= 1'b1;
          end
        end
        BP_REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= BP_IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
          end
        end
        default: begin
          state_q          <= BP_IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
          stall_q          <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_front    = flush_q;
  assign stall_ex       = stall_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: expected redirect PCs are queued at
// issue time and retired by a monitor at each redirect handshake.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jump;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken, branch_taken;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush_front, stall_ex;
  logic [31:0] branch_cnt, mispred_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  branch_resolve_ctrl #(.WIDTH(32), .BHT_DEPTH(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .branch_taken   (branch_taken),
    .id_pc          (id_pc),
    .id_pred_taken  (id_pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush_front    (flush_front),
    .stall_ex       (stall_ex),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: flush/stall track redirect, and each handshake retires one queued PC.
  always @(negedge clk) begin
    if (!rst) begin
      if (redirect_valid) begin
        check("flush_with_redirect", {31'd0, flush_front}, 32'd1);
        check("stall_with_redirect", {31'd0, stall_ex}, 32'd1);
        if (redirect_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_redirect: got pc 0x%08h expected no redirect", redirect_pc);
          end else begin
            check("sb_redirect_pc", redirect_pc, exp_q.pop_front());
          end
        end
      end else begin
        check("flush_idle", {31'd0, flush_front}, 32'd0);
        check("stall_idle", {31'd0, stall_ex}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid      = 1'b0;
    ex_is_branch  = 1'b0;
    ex_is_jump    = 1'b0;
    branch_taken  = 1'b0;
    ex_pred_taken = 1'b0;
  endtask

  task automatic drive_ex(input logic br, input logic jp, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pred, input logic taken);
    ex_valid      = 1'b1;
    ex_is_branch  = br;
    ex_is_jump    = jp;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
    branch_taken  = taken;
  endtask

  task automatic issue(input logic br, input logic jp, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pred, input logic taken);
    drive_ex(br, jp, pc, tgt, pred, taken);
    step();
    idle_ex();
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic exp);
    id_pc = pc;
    #1;
    check(name, {31'd0, id_pred_taken}, {31'd0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_ex();
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  logic t4_tk_pre  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic t4_nt_pre  [3] = '{1'b1, 1'b1, 1'b0};
  logic t4_nt_post [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b0;
    idle_ex();
    ex_pc = '0;
    ex_target = '0;
    id_pc = '0;
    redirect_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_mispred_cnt", mispred_cnt, 32'd0);
    step();
    step();
    rst = 1'b0;

    // 1: correct prediction, taken BEQ
    lookup("t1_pred_init", 32'h100, 1'b0);
    issue(1'b1, 1'b0, 32'h100, 32'h140, 1'b1, 1'b1);
    check("t1_no_redirect", {31'd0, redirect_valid}, 32'd0);
    check("t1_branch_cnt", branch_cnt, 32'd1);
    check("t1_mispred_cnt", mispred_cnt, 32'd0);
    lookup("t1_pred_trained", 32'h100, 1'b1);
    step();
    check("t1_still_idle", {31'd0, redirect_valid}, 32'd0);

    // 2: predicted taken, actually not taken -> fall-through redirect
    exp_q.push_back(32'h204);
    issue(1'b1, 1'b0, 32'h200, 32'h208, 1'b1, 1'b0);
    check("t2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("t2_redirect_pc", redirect_pc, 32'h204);
    check("t2_flush", {31'd0, flush_front}, 32'd1);
    check("t2_stall", {31'd0, stall_ex}, 32'd1);
    check("t2_branch_cnt", branch_cnt, 32'd2);
    check("t2_mispred_cnt", mispred_cnt, 32'd1);
    step();
    check("t2_back_idle", {31'd0, redirect_valid}, 32'd0);
    check("t2_flush_drop", {31'd0, flush_front}, 32'd0);
    lookup("t2_pred_untrained", 32'h200, 1'b0);

    // 3: backpressure; a wrong-path branch sits in EX throughout
    redirect_ready = 1'b0;
    exp_q.push_back(32'h480);
    drive_ex(1'b1, 1'b0, 32'h400, 32'h480, 1'b0, 1'b1);
    step();
    drive_ex(1'b1, 1'b0, 32'h500, 32'h600, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) redirect_ready = 1'b1;
      check("t3_hold_valid", {31'd0, redirect_valid}, 32'd1);
      check("t3_hold_pc", redirect_pc, 32'h480);
      step();
    end
    idle_ex();
    check("t3_idle_5th", {31'd0, redirect_valid}, 32'd0);
    check("t3_branch_cnt", branch_cnt, 32'd3);
    check("t3_mispred_cnt", mispred_cnt, 32'd2);
    lookup("t3_no_wrongpath_train", 32'h400, 1'b1);

    do_reset();

    // 4: saturation at both ends of the counter
    for (int i = 0; i < 4; i++) begin
      id_pc = 32'h300;
      drive_ex(1'b1, 1'b0, 32'h300, 32'h340, 1'b1, 1'b1);
      #1;
      check("t4_tk_pre_update_read", {31'd0, id_pred_taken}, {31'd0, t4_tk_pre[i]});
      step();
      idle_ex();
      lookup("t4_tk_post", 32'h300, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h300;
      drive_ex(1'b1, 1'b0, 32'h300, 32'h340, 1'b0, 1'b0);
      #1;
      check("t4_nt_pre_update_read", {31'd0, id_pred_taken}, {31'd0, t4_nt_pre[i]});
      step();
      idle_ex();
      lookup("t4_nt_post", 32'h300, t4_nt_post[i]);
    end
    issue(1'b1, 1'b0, 32'h300, 32'h340, 1'b1, 1'b1);
    lookup("t4_floor_then_taken", 32'h300, 1'b0);
    check("t4_branch_cnt", branch_cnt, 32'd8);
    check("t4_mispred_cnt", mispred_cnt, 32'd0);

    // non-control instruction leaves everything alone
    issue(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
    check("nc_branch_cnt", branch_cnt, 32'd8);
    check("nc_no_redirect", {31'd0, redirect_valid}, 32'd0);

    // 5: JAL at top of address space, then not-taken branch wrapping pc+4
    exp_q.push_back(32'h0);
    issue(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    check("t5_jal_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("t5_jal_redirect_pc", redirect_pc, 32'h0);
    check("t5_jal_branch_cnt", branch_cnt, 32'd9);
    check("t5_jal_mispred_cnt", mispred_cnt, 32'd1);
    lookup("t5_jal_not_trained", 32'hFFFF_FFFC, 1'b0);
    step();
    exp_q.push_back(32'h0);
    issue(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0);
    check("t5_wrap_redirect_pc", redirect_pc, 32'h0);
    check("t5_wrap_mispred_cnt", mispred_cnt, 32'd2);
    step();

    // 6: asynchronous reset in the middle of a stalled redirect
    redirect_ready = 1'b0;
    issue(1'b1, 1'b0, 32'h700, 32'h800, 1'b1, 1'b0);
    check("t6_pre_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_async_valid", {31'd0, redirect_valid}, 32'd0);
    check("t6_async_pc", redirect_pc, 32'd0);
    check("t6_async_flush", {31'd0, flush_front}, 32'd0);
    check("t6_async_stall", {31'd0, stall_ex}, 32'd0);
    check("t6_async_branch_cnt", branch_cnt, 32'd0);
    check("t6_async_mispred_cnt", mispred_cnt, 32'd0);
    step();
    step();
    rst = 1'b0;
    redirect_ready = 1'b1;
    step();
    check("t6_idle_after", {31'd0, redirect_valid}, 32'd0);
    check("t6_branch_cnt", branch_cnt, 32'd0);
    for (int i = 0; i < 64; i++) begin
      lookup("t6_entry_not_taken", 32'(i) << 2, 1'b0);
    end
    issue(1'b1, 1'b0, 32'h0, 32'h40, 1'b1, 1'b1);
    lookup("t6_entry_weak", 32'h0, 1'b1);
    step();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
